// File: rtl/rename_if.sv
// Rename-stage bundle: decode group in, freelist head, renamed group out, commit
// and flush. The rename unit sits on the slave side of this interface.
interface rename_if #(
    parameter int ARCH_REG_WIDTH = 5,
    parameter int PREG_WIDTH     = 6
) ();
    logic                      in_valid_first_i;
    logic                      in_valid_second_i;
    logic [ARCH_REG_WIDTH-1:0] rs1_first_i;
    logic [ARCH_REG_WIDTH-1:0] rs2_first_i;
    logic [ARCH_REG_WIDTH-1:0] rd_first_i;
    logic                      rd_wen_first_i;
    logic [ARCH_REG_WIDTH-1:0] rs1_second_i;
    logic [ARCH_REG_WIDTH-1:0] rs2_second_i;
    logic [ARCH_REG_WIDTH-1:0] rd_second_i;
    logic                      rd_wen_second_i;
    logic                      in_ready_o;

    logic                      fl_rd_first_en_o;
    logic                      fl_rd_second_en_o;
    logic [PREG_WIDTH-1:0]     fl_rdata_first_i;
    logic [PREG_WIDTH-1:0]     fl_rdata_second_i;
    logic [4:0]                fl_num_i;

    logic                      out_valid_first_o;
    logic [PREG_WIDTH-1:0]     prs1_first_o;
    logic [PREG_WIDTH-1:0]     prs2_first_o;
    logic [PREG_WIDTH-1:0]     prd_first_o;
    logic [PREG_WIDTH-1:0]     old_prd_first_o;
    logic                      rd_wen_first_o;
    logic                      out_valid_second_o;
    logic [PREG_WIDTH-1:0]     prs1_second_o;
    logic [PREG_WIDTH-1:0]     prs2_second_o;
    logic [PREG_WIDTH-1:0]     prd_second_o;
    logic [PREG_WIDTH-1:0]     old_prd_second_o;
    logic                      rd_wen_second_o;
    logic                      out_ready_i;

    logic                      cm_en_first_i;
    logic [ARCH_REG_WIDTH-1:0] cm_rd_first_i;
    logic [PREG_WIDTH-1:0]     cm_prd_first_i;
    logic                      cm_en_second_i;
    logic [ARCH_REG_WIDTH-1:0] cm_rd_second_i;
    logic [PREG_WIDTH-1:0]     cm_prd_second_i;

    logic                      flush_i;

    modport slave (
        input  in_valid_first_i, in_valid_second_i,
        input  rs1_first_i, rs2_first_i, rd_first_i, rd_wen_first_i,
        input  rs1_second_i, rs2_second_i, rd_second_i, rd_wen_second_i,
        output in_ready_o,
        output fl_rd_first_en_o, fl_rd_second_en_o,
        input  fl_rdata_first_i, fl_rdata_second_i, fl_num_i,
        output out_valid_first_o, prs1_first_o, prs2_first_o, prd_first_o,
        output old_prd_first_o, rd_wen_first_o,
        output out_valid_second_o, prs1_second_o, prs2_second_o, prd_second_o,
        output old_prd_second_o, rd_wen_second_o,
        input  out_ready_i,
        input  cm_en_first_i, cm_rd_first_i, cm_prd_first_i,
        input  cm_en_second_i, cm_rd_second_i, cm_prd_second_i,
        input  flush_i
    );

    modport master (
        output in_valid_first_i, in_valid_second_i,
        output rs1_first_i, rs2_first_i, rd_first_i, rd_wen_first_i,
        output rs1_second_i, rs2_second_i, rd_second_i, rd_wen_second_i,
        input  in_ready_o,
        input  fl_rd_first_en_o, fl_rd_second_en_o,
        output fl_rdata_first_i, fl_rdata_second_i, fl_num_i,
        input  out_valid_first_o, prs1_first_o, prs2_first_o, prd_first_o,
        input  old_prd_first_o, rd_wen_first_o,
        input  out_valid_second_o, prs1_second_o, prs2_second_o, prd_second_o,
        input  old_prd_second_o, rd_wen_second_o,
        output out_ready_i,
        output cm_en_first_i, cm_rd_first_i, cm_prd_first_i,
        output cm_en_second_i, cm_rd_second_i, cm_prd_second_i,
        output flush_i
    );
endinterface

// File: rtl/rename_unit.sv
// Two-wide register rename stage: speculative and committed alias tables,
// freelist pop control, intra-group bypass and a one-deep output register.
module rename_unit #(
    parameter int ARCH_REG_WIDTH = 5,
    parameter int PREG_WIDTH     = 6
) (
    input  logic    clk,
    input  logic    rst,
    rename_if.slave rn
);
    localparam int NUM_ARCH = 1 << ARCH_REG_WIDTH;

    typedef logic [PREG_WIDTH-1:0]     tag_t;
    typedef logic [ARCH_REG_WIDTH-1:0] areg_t;

    // The tables are flop arrays: flush copies every entry in a single cycle.
    tag_t spec_rat_reg [NUM_ARCH];
    tag_t cm_rat_reg   [NUM_ARCH];
    tag_t cm_rat_next  [NUM_ARCH];

    areg_t      rs1_s [2];
    areg_t      rs2_s [2];
    areg_t      rd_s  [2];
    tag_t       new_tag [2];
    logic [1:0] alloc_s;
    logic [1:0] alloc_cnt;
    logic       accept;

    tag_t prs1_c [2];
    tag_t prs2_c [2];
    tag_t prd_c  [2];
    tag_t old_c  [2];

    logic [1:0] out_valid_reg;
    logic [1:0] rd_wen_reg;
    tag_t       prs1_reg [2];
    tag_t       prs2_reg [2];
    tag_t       prd_reg  [2];
    tag_t       old_reg  [2];

    always_comb begin
        rs1_s[0]   = rn.rs1_first_i;
        rs2_s[0]   = rn.rs2_first_i;
        rd_s[0]    = rn.rd_first_i;
        rs1_s[1]   = rn.rs1_second_i;
        rs2_s[1]   = rn.rs2_second_i;
        rd_s[1]    = rn.rd_second_i;
        new_tag[0] = rn.fl_rdata_first_i;
        new_tag[1] = rn.fl_rdata_second_i;
        alloc_s[0] = rn.in_valid_first_i & rn.rd_wen_first_i & (rn.rd_first_i != '0);
        alloc_s[1] = rn.in_valid_second_i & rn.rd_wen_second_i & (rn.rd_second_i != '0);
    end

    assign alloc_cnt     = 2'(alloc_s[0]) + 2'(alloc_s[1]);
    assign rn.in_ready_o = !rn.flush_i & (!out_valid_reg[0] | rn.out_ready_i)
                         & ({3'b000, alloc_cnt} <= rn.fl_num_i);
    assign accept        = rn.in_ready_o & rn.in_valid_first_i & !rst;

    // Each slot pops its own freelist head, so a lone second slot takes the second tag.
    assign rn.fl_rd_first_en_o  = accept & alloc_s[0];
    assign rn.fl_rd_second_en_o = accept & alloc_s[1];

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            prs1_c[s] = (rs1_s[s] == '0) ? '0 : spec_rat_reg[rs1_s[s]];
            prs2_c[s] = (rs2_s[s] == '0) ? '0 : spec_rat_reg[rs2_s[s]];
            prd_c[s]  = alloc_s[s] ? new_tag[s] : '0;
            old_c[s]  = alloc_s[s] ? spec_rat_reg[rd_s[s]] : '0;
        end
        // The second slot sees the first slot's mapping as if renamed one after the other.
        if (alloc_s[0]) begin
            if (rs1_s[1] == rd_s[0]) prs1_c[1] = new_tag[0];
            if (rs2_s[1] == rd_s[0]) prs2_c[1] = new_tag[0];
            if (alloc_s[1] && (rd_s[1] == rd_s[0])) old_c[1] = new_tag[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= '0;
            rd_wen_reg    <= '0;
            for (int s = 0; s < 2; s++) begin
                prs1_reg[s] <= '0;
                prs2_reg[s] <= '0;
                prd_reg[s]  <= '0;
                old_reg[s]  <= '0;
            end
        end else if (rn.flush_i) begin
            out_valid_reg <= '0;
        end else if (accept) begin
            out_valid_reg <= {rn.in_valid_second_i, 1'b1};
            rd_wen_reg    <= alloc_s;
            for (int s = 0; s < 2; s++) begin
                prs1_reg[s] <= prs1_c[s];
                prs2_reg[s] <= prs2_c[s];
                prd_reg[s]  <= prd_c[s];
                old_reg[s]  <= old_c[s];
            end
        end else if (rn.out_ready_i) begin
            out_valid_reg <= '0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ARCH; gi++) begin : g_rat
            if (gi == 0) begin : g_zero
                assign cm_rat_next[gi] = cm_rat_reg[gi];
            end else begin : g_nz
                // Second commit slot is younger, so it overrides on a shared rd.
                assign cm_rat_next[gi] =
                    (rn.cm_en_second_i && (rn.cm_rd_second_i == ARCH_REG_WIDTH'(gi))) ? rn.cm_prd_second_i :
                    (rn.cm_en_first_i  && (rn.cm_rd_first_i  == ARCH_REG_WIDTH'(gi))) ? rn.cm_prd_first_i  :
                    cm_rat_reg[gi];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cm_rat_reg[gi] <= PREG_WIDTH'(gi);
                end else begin
                    cm_rat_reg[gi] <= cm_rat_next[gi];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    spec_rat_reg[gi] <= PREG_WIDTH'(gi);
                end else if (rn.flush_i) begin
                    spec_rat_reg[gi] <= cm_rat_next[gi];
                end else if (accept && alloc_s[1] && (rd_s[1] == ARCH_REG_WIDTH'(gi))) begin
                    spec_rat_reg[gi] <= new_tag[1];
                end else if (accept && alloc_s[0] && (rd_s[0] == ARCH_REG_WIDTH'(gi))) begin
                    spec_rat_reg[gi] <= new_tag[0];
                end
            end
        end
    endgenerate

    assign rn.out_valid_first_o  = out_valid_reg[0];
    assign rn.prs1_first_o       = prs1_reg[0];
    assign rn.prs2_first_o       = prs2_reg[0];
    assign rn.prd_first_o        = prd_reg[0];
    assign rn.old_prd_first_o    = old_reg[0];
    assign rn.rd_wen_first_o     = rd_wen_reg[0];
    assign rn.out_valid_second_o = out_valid_reg[1];
    assign rn.prs1_second_o      = prs1_reg[1];
    assign rn.prs2_second_o      = prs2_reg[1];
    assign rn.prd_second_o       = prd_reg[1];
    assign rn.old_prd_second_o   = old_reg[1];
    assign rn.rd_wen_second_o    = rd_wen_reg[1];
endmodule

// File: tb/tb_rename_unit.sv
// Bench for rename_unit: directed vector table, hand-written stall/reset/flush
// sequences, then random traffic against a sequential-rename reference model.
module tb_rename_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rename_if #(.ARCH_REG_WIDTH(5), .PREG_WIDTH(6)) rn_bus ();

    rename_unit #(.ARCH_REG_WIDTH(5), .PREG_WIDTH(6)) u_dut (
        .clk (clk),
        .rst (rst),
        .rn  (rn_bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int v1, v2, rs1a, rs2a, rda, wa, rs1b, rs2b, rdb, wb, taga, tagb, num;
        int rdy, popa, popb, ova, ovb, prda, prdb, olda, oldb, p1a, p2a, p1b, p2b;
    } vec_t;

    vec_t vecs [7];

    // Reference state: plain arrays indexed by architectural register.
    int m_spec [32];
    int m_cm   [32];
    int e_ov   [2];
    int e_prs1 [2];
    int e_prs2 [2];
    int e_prd  [2];
    int e_old  [2];
    int e_wen  [2];

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        rn_bus.in_valid_first_i  = 1'b0;
        rn_bus.in_valid_second_i = 1'b0;
        rn_bus.rs1_first_i  = '0; rn_bus.rs2_first_i  = '0;
        rn_bus.rd_first_i   = '0; rn_bus.rd_wen_first_i  = 1'b0;
        rn_bus.rs1_second_i = '0; rn_bus.rs2_second_i = '0;
        rn_bus.rd_second_i  = '0; rn_bus.rd_wen_second_i = 1'b0;
        rn_bus.fl_rdata_first_i  = '0;
        rn_bus.fl_rdata_second_i = '0;
        rn_bus.fl_num_i    = '0;
        rn_bus.out_ready_i = 1'b1;
        rn_bus.cm_en_first_i  = 1'b0; rn_bus.cm_rd_first_i  = '0; rn_bus.cm_prd_first_i  = '0;
        rn_bus.cm_en_second_i = 1'b0; rn_bus.cm_rd_second_i = '0; rn_bus.cm_prd_second_i = '0;
        rn_bus.flush_i = 1'b0;
    endtask

    task automatic drive_vec(input vec_t v);
        rn_bus.in_valid_first_i  = 1'(v.v1);
        rn_bus.in_valid_second_i = 1'(v.v2);
        rn_bus.rs1_first_i  = 5'(v.rs1a); rn_bus.rs2_first_i  = 5'(v.rs2a);
        rn_bus.rd_first_i   = 5'(v.rda);  rn_bus.rd_wen_first_i  = 1'(v.wa);
        rn_bus.rs1_second_i = 5'(v.rs1b); rn_bus.rs2_second_i = 5'(v.rs2b);
        rn_bus.rd_second_i  = 5'(v.rdb);  rn_bus.rd_wen_second_i = 1'(v.wb);
        rn_bus.fl_rdata_first_i  = 6'(v.taga);
        rn_bus.fl_rdata_second_i = 6'(v.tagb);
        rn_bus.fl_num_i = 5'(v.num);
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic apply_vec(input int idx, input vec_t v);
        drive_vec(v);
        #1;
        chk("vec_in_ready", int'(rn_bus.in_ready_o), v.rdy);
        chk("vec_pop_first", int'(rn_bus.fl_rd_first_en_o), v.popa);
        chk("vec_pop_second", int'(rn_bus.fl_rd_second_en_o), v.popb);
        @(posedge clk); #1;
        chk("vec_valid_first", int'(rn_bus.out_valid_first_o), v.ova);
        chk("vec_valid_second", int'(rn_bus.out_valid_second_o), v.ovb);
        if (v.ova != 0) begin
            chk("vec_prd_first", int'(rn_bus.prd_first_o), v.prda);
            chk("vec_old_first", int'(rn_bus.old_prd_first_o), v.olda);
            chk("vec_prs1_first", int'(rn_bus.prs1_first_o), v.p1a);
            chk("vec_prs2_first", int'(rn_bus.prs2_first_o), v.p2a);
            chk("vec_wen_first", int'(rn_bus.rd_wen_first_o), int'(v.prda != 0));
        end
        if (v.ovb != 0) begin
            chk("vec_prd_second", int'(rn_bus.prd_second_o), v.prdb);
            chk("vec_old_second", int'(rn_bus.old_prd_second_o), v.oldb);
            chk("vec_prs1_second", int'(rn_bus.prs1_second_o), v.p1b);
            chk("vec_prs2_second", int'(rn_bus.prs2_second_o), v.p2b);
            chk("vec_wen_second", int'(rn_bus.rd_wen_second_o), int'(v.prdb != 0));
        end
        $display("[TB] vec %0d rdy=%0d prd=%0d/%0d old=%0d/%0d", idx, rn_bus.in_ready_o,
                 rn_bus.prd_first_o, rn_bus.prd_second_o, rn_bus.old_prd_first_o, rn_bus.old_prd_second_o);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            m_spec[i] = i;
            m_cm[i]   = i;
        end
        for (int s = 0; s < 2; s++) begin
            e_ov[s] = 0; e_prs1[s] = 0; e_prs2[s] = 0; e_prd[s] = 0; e_old[s] = 0; e_wen[s] = 0;
        end
    endtask

    // One random cycle against a model that renames slot first, then slot second,
    // through a working copy of the map table.
    task automatic rand_cycle(input int n);
        int v1, v2, rs1a, rs2a, rda, wa, rs1b, rs2b, rdb, wb, taga, tagb, num, ordy, fl;
        int cea, cra, cpa, ceb, crb, cpb;
        int aa, ab, rdy, acc;
        int tmp [32];
        int r1a, r2a, oa, r1b, r2b, ob;
        v1 = int'($urandom_range(0, 3) != 0);
        v2 = (v1 != 0) ? int'($urandom_range(0, 1)) : 0;
        rs1a = $urandom_range(0, 7); rs2a = $urandom_range(0, 7); rda = $urandom_range(0, 7);
        rs1b = $urandom_range(0, 7); rs2b = $urandom_range(0, 7); rdb = $urandom_range(0, 7);
        wa = $urandom_range(0, 1); wb = $urandom_range(0, 1);
        taga = $urandom_range(0, 63); tagb = $urandom_range(0, 63);
        num = $urandom_range(0, 3);
        ordy = int'($urandom_range(0, 3) != 0);
        fl = int'($urandom_range(0, 15) == 0);
        cea = $urandom_range(0, 1); cra = $urandom_range(0, 7); cpa = $urandom_range(0, 63);
        ceb = $urandom_range(0, 1); crb = $urandom_range(0, 7); cpb = $urandom_range(0, 63);

        drive_vec('{v1, v2, rs1a, rs2a, rda, wa, rs1b, rs2b, rdb, wb, taga, tagb, num,
                    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        rn_bus.out_ready_i = 1'(ordy);
        rn_bus.flush_i = 1'(fl);
        rn_bus.cm_en_first_i  = 1'(cea); rn_bus.cm_rd_first_i  = 5'(cra); rn_bus.cm_prd_first_i  = 6'(cpa);
        rn_bus.cm_en_second_i = 1'(ceb); rn_bus.cm_rd_second_i = 5'(crb); rn_bus.cm_prd_second_i = 6'(cpb);

        aa  = int'(v1 != 0 && wa != 0 && rda != 0);
        ab  = int'(v2 != 0 && wb != 0 && rdb != 0);
        rdy = int'(fl == 0 && (e_ov[0] == 0 || ordy != 0) && (aa + ab <= num));
        acc = int'(rdy != 0 && v1 != 0);
        #1;
        chk("rnd_in_ready", int'(rn_bus.in_ready_o), rdy);
        chk("rnd_pop_first", int'(rn_bus.fl_rd_first_en_o), int'(acc != 0 && aa != 0));
        chk("rnd_pop_second", int'(rn_bus.fl_rd_second_en_o), int'(acc != 0 && ab != 0));

        tmp = m_spec;
        r1a = tmp[rs1a]; r2a = tmp[rs2a]; oa = (aa != 0) ? tmp[rda] : 0;
        if (aa != 0) tmp[rda] = taga;
        r1b = tmp[rs1b]; r2b = tmp[rs2b]; ob = (ab != 0) ? tmp[rdb] : 0;
        if (ab != 0) tmp[rdb] = tagb;

        if (cea != 0 && cra != 0) m_cm[cra] = cpa;
        if (ceb != 0 && crb != 0) m_cm[crb] = cpb;

        if (fl != 0) begin
            m_spec = m_cm;
            e_ov[0] = 0; e_ov[1] = 0;
        end else if (acc != 0) begin
            m_spec = tmp;
            e_ov[0] = 1;  e_ov[1] = v2;
            e_prs1[0] = r1a; e_prs2[0] = r2a; e_prd[0] = (aa != 0) ? taga : 0; e_old[0] = oa; e_wen[0] = aa;
            e_prs1[1] = r1b; e_prs2[1] = r2b; e_prd[1] = (ab != 0) ? tagb : 0; e_old[1] = ob; e_wen[1] = ab;
        end else if (ordy != 0) begin
            e_ov[0] = 0; e_ov[1] = 0;
        end

        @(posedge clk); #1;
        chk("rnd_valid_first", int'(rn_bus.out_valid_first_o), e_ov[0]);
        chk("rnd_valid_second", int'(rn_bus.out_valid_second_o), e_ov[1]);
        if (e_ov[0] != 0) begin
            chk("rnd_prs1_first", int'(rn_bus.prs1_first_o), e_prs1[0]);
            chk("rnd_prs2_first", int'(rn_bus.prs2_first_o), e_prs2[0]);
            chk("rnd_prd_first", int'(rn_bus.prd_first_o), e_prd[0]);
            chk("rnd_old_first", int'(rn_bus.old_prd_first_o), e_old[0]);
            chk("rnd_wen_first", int'(rn_bus.rd_wen_first_o), e_wen[0]);
        end
        if (e_ov[1] != 0) begin
            chk("rnd_prs1_second", int'(rn_bus.prs1_second_o), e_prs1[1]);
            chk("rnd_prs2_second", int'(rn_bus.prs2_second_o), e_prs2[1]);
            chk("rnd_prd_second", int'(rn_bus.prd_second_o), e_prd[1]);
            chk("rnd_old_second", int'(rn_bus.old_prd_second_o), e_old[1]);
            chk("rnd_wen_second", int'(rn_bus.rd_wen_second_o), e_wen[1]);
        end
        $display("[TB] rnd %0d acc=%0d flush=%0d prd=%0d/%0d", n, acc, fl,
                 rn_bus.prd_first_o, rn_bus.prd_second_o);
        @(negedge clk);
    endtask

    // Drives a single first-slot group, plain sources, optional allocation.
    task automatic drive_first(input int rs1, input int rs2, input int rd, input int wen, input int tag);
        drive_vec('{1, 0, rs1, rs2, rd, wen, 0, 0, 0, 0, tag, 0, 10,
                    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1,1,1,2,3,1,3,0,4,1,32,33,31, 1,1,1,1,1,32,33,3,4,1,2,32,0};
        vecs[1] = '{1,1,3,4,5,1,5,4,5,1,34,35,20, 1,1,1,1,1,34,35,5,34,32,33,34,33};
        vecs[2] = '{1,1,0,0,6,1,0,0,7,1,36,37,1,  0,0,0,0,0,0,0,0,0,0,0,0,0};
        vecs[3] = '{1,1,0,0,6,1,0,0,7,1,36,37,2,  1,1,1,1,1,36,37,6,7,0,0,0,0};
        vecs[4] = '{1,1,0,0,9,0,5,0,8,1,50,38,1,  1,0,1,1,1,0,38,0,8,0,0,35,0};
        vecs[5] = '{1,0,5,0,0,1,0,0,0,0,44,45,0,  1,0,0,1,0,0,0,0,0,35,0,0,0};
        vecs[6] = '{0,0,8,0,0,0,0,0,0,0,0,0,5,    1,0,0,0,0,0,0,0,0,0,0,0,0};

        clear_inputs();
        // A renamable group is offered during reset; it must not pop or load.
        drive_vec(vecs[0]);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid_first", int'(rn_bus.out_valid_first_o), 0);
        chk("rst_valid_second", int'(rn_bus.out_valid_second_o), 0);
        chk("rst_prd_first", int'(rn_bus.prd_first_o), 0);
        chk("rst_old_second", int'(rn_bus.old_prd_second_o), 0);
        chk("rst_pop_first", int'(rn_bus.fl_rd_first_en_o), 0);
        chk("rst_pop_second", int'(rn_bus.fl_rd_second_en_o), 0);
        rst = 1'b0;
        clear_inputs();

        for (int i = 0; i < 7; i++) apply_vec(i, vecs[i]);
        clear_inputs();

        // Output stall: accepted group stays put while the next waits.
        drive_first(0, 0, 10, 1, 40);
        #1;
        chk("stall_pre_ready", int'(rn_bus.in_ready_o), 1);
        @(posedge clk); #1;
        chk("stall_pre_prd", int'(rn_bus.prd_first_o), 40);
        @(negedge clk);
        drive_first(0, 0, 11, 1, 41);
        rn_bus.out_ready_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("stall_ready", int'(rn_bus.in_ready_o), 0);
            chk("stall_pop", int'(rn_bus.fl_rd_first_en_o), 0);
            @(posedge clk); #1;
            chk("stall_valid", int'(rn_bus.out_valid_first_o), 1);
            chk("stall_prd", int'(rn_bus.prd_first_o), 40);
            chk("stall_old", int'(rn_bus.old_prd_first_o), 10);
            $display("[TB] stall cycle %0d prd=%0d", c, rn_bus.prd_first_o);
            @(negedge clk);
        end
        rn_bus.out_ready_i = 1'b1;
        #1;
        chk("stall_release_pop", int'(rn_bus.fl_rd_first_en_o), 1);
        @(posedge clk); #1;
        chk("stall_release_prd", int'(rn_bus.prd_first_o), 41);
        chk("stall_release_old", int'(rn_bus.old_prd_first_o), 11);
        @(negedge clk);

        // Reset in the middle of a live group discards it and restores the map.
        drive_first(0, 0, 12, 1, 42);
        rst = 1'b1;
        #1;
        chk("midrst_pop", int'(rn_bus.fl_rd_first_en_o), 0);
        @(posedge clk); #1;
        chk("midrst_valid", int'(rn_bus.out_valid_first_o), 0);
        @(negedge clk);
        rst = 1'b0;
        drive_first(12, 10, 0, 0, 0);
        @(posedge clk); #1;
        chk("midrst_map12", int'(rn_bus.prs1_first_o), 12);
        chk("midrst_map10", int'(rn_bus.prs2_first_o), 10);
        $display("[TB] midrst prs=%0d/%0d", rn_bus.prs1_first_o, rn_bus.prs2_first_o);
        @(negedge clk);

        // Flush with a same-cycle commit of the speculative rd=7 mapping.
        drive_vec('{1,1,0,0,7,1,0,0,3,1,40,41,10, 0,0,0,0,0,0,0,0,0,0,0,0,0});
        @(posedge clk); #1;
        chk("flush_pre_prd", int'(rn_bus.prd_first_o), 40);
        chk("flush_pre_old2", int'(rn_bus.old_prd_second_o), 3);
        @(negedge clk);
        drive_first(0, 0, 13, 1, 50);
        rn_bus.flush_i = 1'b1;
        rn_bus.cm_en_first_i = 1'b1; rn_bus.cm_rd_first_i = 5'd7; rn_bus.cm_prd_first_i = 6'd40;
        #1;
        chk("flush_ready", int'(rn_bus.in_ready_o), 0);
        chk("flush_pop", int'(rn_bus.fl_rd_first_en_o), 0);
        @(posedge clk); #1;
        chk("flush_valid_first", int'(rn_bus.out_valid_first_o), 0);
        chk("flush_valid_second", int'(rn_bus.out_valid_second_o), 0);
        @(negedge clk);
        clear_inputs();
        drive_vec('{1,1,7,3,0,0,13,0,0,0,0,0,10, 0,0,0,0,0,0,0,0,0,0,0,0,0});
        @(posedge clk); #1;
        chk("flush_map7", int'(rn_bus.prs1_first_o), 40);
        chk("flush_map3", int'(rn_bus.prs2_first_o), 3);
        chk("flush_map13", int'(rn_bus.prs1_second_o), 13);
        $display("[TB] flush prs=%0d/%0d/%0d", rn_bus.prs1_first_o, rn_bus.prs2_first_o, rn_bus.prs1_second_o);
        @(negedge clk);

        do_reset();
        for (int n = 0; n < 400; n++) rand_cycle(n);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rename_unit.md
RENAME_UNIT -- requirements
Module: rename_unit

Interface
REQ-001 SHALL have parameter ARCH_REG_WIDTH, default 5, meaning architectural register index width (32 arch regs).
REQ-002 SHALL have parameter PREG_WIDTH, default 6, meaning physical register tag width.
REQ-003 SHALL have ports clk (in, 1, clock) and rst (in, 1, synchronous active-high reset); one clock domain.
REQ-004 SHALL have in_valid_first_i / in_valid_second_i (in, 1 each), meaning upstream decode slot valid; slot second is never valid without slot first.
REQ-005 SHALL have per slot s in {first, second}: rs1_s_i, rs2_s_i, rd_s_i (in, ARCH_REG_WIDTH each) and rd_wen_s_i (in, 1).
REQ-006 SHALL have in_ready_o (in/out: out, 1), meaning the whole group is accepted this cycle.
REQ-007 SHALL have fl_rd_first_en_o / fl_rd_second_en_o (out, 1 each), meaning freelist pop strobes.
REQ-008 SHALL have fl_rdata_first_i / fl_rdata_second_i (in, PREG_WIDTH each) and fl_num_i (in, 5), meaning freelist head tags and occupancy.
REQ-009 SHALL have per slot: out_valid_s_o (out, 1), prs1_s_o, prs2_s_o, prd_s_o, old_prd_s_o (out, PREG_WIDTH each), rd_wen_s_o (out, 1); out_ready_i (in, 1).
REQ-010 SHALL have commit ports cm_en_s_i (in, 1), cm_rd_s_i (in, ARCH_REG_WIDTH), cm_prd_s_i (in, PREG_WIDTH) for both slots.
REQ-011 SHALL have flush_i (in, 1), meaning squash all speculative state.

Function
REQ-012 SHALL hold a speculative RAT (spec_rat) and committed RAT (cm_rat), 32 entries x PREG_WIDTH each.
REQ-013 Slot s SHALL need allocation (alloc_s) iff in_valid_s_i & rd_wen_s_i & rd_s_i != 0.
REQ-014 in_ready_o SHALL = !flush_i & (!out_valid_first_o | out_ready_i) & (alloc_first + alloc_second <= fl_num_i); combinational.
REQ-015 Accept SHALL = in_ready_o & in_valid_first_i; groups are all-or-nothing, never split.
REQ-016 On accept: alloc both -> both pop enables; first only -> fl_rd_first_en_o, tag fl_rdata_first_i; second only -> fl_rd_second_en_o only, tag fl_rdata_second_i; enables never asserted without accept.
REQ-017 Slot-first sources SHALL read spec_rat; slot-second rs1/rs2 equal to rd_first with alloc_first SHALL take slot-first new tag (intra-group bypass).
REQ-018 old_prd_s SHALL be spec_rat[rd_s]; slot-second with rd_second == rd_first and alloc_first SHALL take slot-first new tag.
REQ-019 Non-allocating slot SHALL output prd = 0, old_prd = 0, rd_wen = 0; reads of arch reg 0 SHALL yield tag 0.
REQ-020 On accept spec_rat SHALL update at next edge; same rd in both slots -> slot-second tag wins.
REQ-021 Output register SHALL load on accept (latency 1 cycle); valid clears when out_ready_i & !accept; holds when !out_ready_i.
REQ-022 Commit SHALL write cm_rat[cm_rd_s_i] <= cm_prd_s_i when cm_en_s_i & cm_rd_s_i != 0; second slot wins on same rd.
REQ-023 flush_i SHALL clear both out_valid next cycle, copy cm_rat (including same-cycle commits) into spec_rat, block accept and pops.
REQ-024 Unaccepted/invalid cycles SHALL leave spec_rat and outputs' data unchanged.

Reset
REQ-025 rst SHALL set spec_rat[i] = cm_rat[i] = i, all out_valid = 0, all tag outputs = 0, pop enables = 0.
REQ-026 rst SHALL take priority over flush_i, commit and accept; mid-operation reset discards in-flight group.

Verification
REQ-027 Reset then group {rd_first=3 wen, rd_second=4 wen}, fl tags 32/33, fl_num=31 -> next cycle prd 32/33, old_prd 3/4, both pops 1 cycle.
REQ-028 rd_first=5, rs1_second=5, rd_second=5 -> prs1_second = prd_first, old_prd_second = prd_first, spec_rat[5] = prd_second.
REQ-029 fl_num_i=1 with two allocating slots -> in_ready_o=0, no pops; fl_num_i=2 -> accepted.
REQ-030 Only slot-second allocates -> only fl_rd_second_en_o high, prd_second = fl_rdata_second_i, prd_first = 0.
REQ-031 out_ready_i=0 with out_valid high -> outputs held, in_ready_o=0, no pops, for 3 cycles.
REQ-032 Rename rd=7 -> 40, commit rd=7 prd=40 same cycle as flush -> out_valid=0, spec_rat[7]=40, other entries = committed values.
